// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite constants, stage-entry types and the alignment rule used by
// masters and slave models alike.
package ahb_lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_BYTE    = 3'b000;
    localparam logic [2:0] HSIZE_HALF    = 3'b001;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef struct packed {
        logic        valid;
        logic        bad;
        logic [31:0] addr;
        logic        write;
        logic [2:0]  size;
        logic [31:0] wdata;
    } a_entry_t;

    typedef struct packed {
        logic valid;
        logic bad;
        logic write;
    } d_entry_t;

    function automatic logic ahb_misaligned(input logic [2:0] size, input logic [31:0] addr);
        case (size)
            HSIZE_BYTE: return 1'b0;
            HSIZE_HALF: return addr[0];
            HSIZE_WORD: return addr[1:0] != 2'b00;
            default:    return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/ahb_lite_master.sv
// Command-stream to single-transfer AHB-Lite initiator with address (A) and data (D) stages.
// Define AHBM_PIPELINE_EN to overlap the next address phase with the current data phase.
module ahb_lite_master
    import ahb_lite_pkg::*;
#(
    parameter logic [3:0] HPROT_VAL = 4'b0011
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_addr,
    input  logic        cmd_write,
    input  logic [2:0]  cmd_size,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic        HMASTLOCK,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic [1:0]  HRESP
);

    a_entry_t    a_q, a_d;
    d_entry_t    d_q, d_d;
    logic [31:0] hwdata_q, hwdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        accept, bus_err;

`ifdef AHBM_PIPELINE_EN
    assign cmd_ready = ~a_q.valid | HREADY;
`else
    assign cmd_ready = ~a_q.valid & ~d_q.valid;
`endif

    assign accept  = cmd_valid & cmd_ready;
    assign bus_err = (HRESP == HRESP_ERROR);

    always_comb begin
        a_d         = a_q;
        d_d         = d_q;
        hwdata_d    = hwdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        if (HREADY) begin
            if (d_q.valid) begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = d_q.bad | bus_err;
                if (!d_q.bad && !d_q.write && !bus_err)
                    rsp_rdata_d = HRDATA;
            end
            d_d      = '{valid: a_q.valid, bad: a_q.bad, write: a_q.write};
            hwdata_d = a_q.wdata;
            a_d      = '0;
        end
        // A is only loadable when empty or draining into D on this edge.
        if (accept)
            a_d = '{valid: 1'b1, bad: ahb_misaligned(cmd_size, cmd_addr), addr: cmd_addr,
                    write: cmd_write, size: cmd_size, wdata: cmd_wdata};
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            a_q         <= '0;
            d_q         <= '0;
            hwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            a_q         <= a_d;
            d_q         <= d_d;
            hwdata_q    <= hwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Bad entries stay IDLE on the bus but still flow through for ordering.
    assign HTRANS    = (a_q.valid & ~a_q.bad) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HADDR     = a_q.addr;
    assign HWRITE    = a_q.write;
    assign HSIZE     = a_q.size;
    assign HWDATA    = hwdata_q;
    assign HBURST    = HBURST_SINGLE;
    assign HPROT     = HPROT_VAL;
    assign HMASTLOCK = 1'b0;

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Bench for ahb_lite_master: RAM-like slave with wait states and an error region,
// plus an in-order reference model of every command's response.
module tb_ahb_lite_master;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        cmd_valid, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [2:0]  cmd_size;
    logic        cmd_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS, HRESP;
    logic        HWRITE, HREADY, HMASTLOCK;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;

`ifdef AHBM_PIPELINE_EN
    localparam int STEP = 1;
    localparam bit PIPE = 1'b1;
`else
    localparam int STEP = 3;
    localparam bit PIPE = 1'b0;
`endif

    ahb_lite_master #(.HPROT_VAL(4'b0011)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_write(cmd_write), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    int n_chk = 0, n_pass = 0;
    int cyc = 0;
    always @(posedge HCLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    // ---------------- slave model ----------------
    bit [7:0]    mem [0:4095];
    logic        sl_act, sl_write, sl_err, sl_ephase;
    logic [31:0] sl_addr;
    logic [2:0]  sl_size;
    int          sl_cnt;
    int          wait_cfg = 0;
    wire  [11:0] sl_base = {sl_addr[11:2], 2'b00};

    always_comb begin
        HREADY = 1'b1;
        HRESP  = 2'b00;
        HRDATA = '0;
        if (sl_act) begin
            if (sl_err) begin
                HRESP  = 2'b01;
                HREADY = sl_ephase;
            end else if (sl_cnt > 0) begin
                HREADY = 1'b0;
            end else if (!sl_write) begin
                HRDATA = {mem[sl_base + 12'd3], mem[sl_base + 12'd2], mem[sl_base + 12'd1], mem[sl_base]};
            end
        end
    end

    always @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            sl_act <= 1'b0; sl_write <= 1'b0; sl_err <= 1'b0; sl_ephase <= 1'b0;
            sl_addr <= '0; sl_size <= '0; sl_cnt <= 0;
        end else if (HREADY) begin
            if (sl_act && sl_write && !sl_err)
                for (int i = 0; i < 4; i++)
                    if (i < (1 << sl_size))
                        mem[12'(sl_addr + 32'(i))] <= HWDATA[8*((sl_addr[1:0] + i) % 4) +: 8];
            sl_act    <= (HTRANS == 2'b10);
            sl_addr   <= HADDR;
            sl_write  <= HWRITE;
            sl_size   <= HSIZE;
            sl_err    <= HADDR[31];
            sl_cnt    <= wait_cfg;
            sl_ephase <= 1'b0;
        end else begin
            if (sl_err) sl_ephase <= 1'b1;
            else if (sl_cnt > 0) sl_cnt <= sl_cnt - 1;
        end
    end

    // ---------------- reference model ----------------
    typedef struct { logic err; logic [31:0] rdata; int lat; } exp_t;
    exp_t        expq[$];
    int          accq[$];
    int          acc_log[$], rsp_log[$], ns_log[$];
    bit [7:0]    ref_mem [0:4095];
    logic [31:0] last_hwdata = '0;
    exp_t        mon_e;
    int          mon_a;

    always @(negedge HCLK) begin
        if (!HRESET) begin
            if (cmd_valid && cmd_ready) begin
                accq.push_back(cyc);
                acc_log.push_back(cyc);
            end
            if (HTRANS == 2'b10 && HREADY) ns_log.push_back(cyc);
            if (sl_act && sl_write && !sl_err && HREADY) last_hwdata = HWDATA;
            if (rsp_valid) begin
                rsp_log.push_back(cyc);
                if (expq.size() == 0 || accq.size() == 0) begin
                    chk("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    mon_e = expq.pop_front();
                    mon_a = accq.pop_front();
                    chk("rsp_err", {31'd0, rsp_err}, {31'd0, mon_e.err});
                    chk("rsp_rdata", rsp_rdata, mon_e.rdata);
                    if (mon_e.lat >= 0) chk("rsp_latency", 32'(cyc - mon_a), 32'(mon_e.lat));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic w, input logic [2:0] s,
                         input logic [31:0] wd, input int lat);
        exp_t        e;
        logic        bad;
        logic [11:0] b;
        bad = (s > 3'd2) || ((a & ((32'd1 << s) - 32'd1)) != 32'd0) || a[31];
        e.err = bad;
        e.rdata = '0;
        e.lat = lat;
        if (!bad && w)
            for (int k = 0; k < (1 << s); k++)
                ref_mem[12'(a + 32'(k))] = wd[8*((a + 32'(k)) % 4) +: 8];
        if (!bad && !w) begin
            b = {a[11:2], 2'b00};
            e.rdata = {ref_mem[b + 12'd3], ref_mem[b + 12'd2], ref_mem[b + 12'd1], ref_mem[b]};
        end
        expq.push_back(e);
        cmd_valid = 1'b1; cmd_addr = a; cmd_write = w; cmd_size = s; cmd_wdata = wd;
        for (int t = 0; ; t++) begin
            @(negedge HCLK);
            if (cmd_ready) break;
            if (t > 100) begin
                chk("accept_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge HCLK);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; ; t++) begin
            tick(1);
            if (expq.size() == 0 && t >= 2) break;
            if (t > 300) begin
                chk("drain_timeout", 32'(expq.size()), 32'd0);
                expq.delete();
                accq.delete();
                break;
            end
        end
        tick(2);
    endtask

    initial begin
        int ns0, r0;
        logic [31:0] a;
        logic [2:0]  s;
        HRESET = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_size = '0; cmd_wdata = '0;
        #2;
        chk("rst_htrans", {30'd0, HTRANS}, 32'd0);
        chk("rst_haddr", HADDR, 32'd0);
        chk("rst_hwrite_hsize", {28'd0, HWRITE, HSIZE}, 32'd0);
        chk("rst_hwdata", HWDATA, 32'd0);
        chk("rst_rsp", {rsp_valid, rsp_err, rsp_rdata[29:0]}, 32'd0);
        chk("fixed_outputs", {21'd0, HBURST, HPROT, HMASTLOCK}, {21'd0, 3'b000, 4'b0011, 1'b0});
        repeat (2) @(negedge HCLK);
        HRESET = 1'b0;
        tick(1);
        chk("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // word write then read back
        ns0 = ns_log.size();
        issue(32'h100, 1'b1, 3'd2, 32'hDEADBEEF, 3);
        drain();
        chk("write_hwdata", last_hwdata, 32'hDEADBEEF);
        issue(32'h100, 1'b0, 3'd2, 32'h0, 3);
        drain();
        chk("wr_rd_nonseq_count", 32'(ns_log.size() - ns0), 32'd2);

        // two wait states on a read
        wait_cfg = 2;
        issue(32'h104, 1'b0, 3'd2, 32'h0, 5);
        drain();
        wait_cfg = 0;

        // two-cycle ERROR followed by a queued good read
        issue(32'h8000_0000, 1'b0, 3'd2, 32'h0, 4);
        issue(32'h100, 1'b0, 3'd2, 32'h0, -1);
        drain();

        // misaligned commands between good neighbours
        ns0 = ns_log.size();
        issue(32'h10, 1'b1, 3'd0, 32'h0000_5A00 >> 8, -1);
        issue(32'h101, 1'b1, 3'd1, 32'h1234_5678, -1);
        issue(32'h102, 1'b0, 3'd2, 32'h0, -1);
        issue(32'h100, 1'b0, 3'd2, 32'h0, -1);
        drain();
        chk("misaligned_nonseq_count", 32'(ns_log.size() - ns0), 32'd2);

        // console stream
        acc_log.delete(); rsp_log.delete(); ns_log.delete();
        issue(32'h4000_0000, 1'b1, 3'd0, 32'h48, 3);
        issue(32'h4000_0000, 1'b1, 3'd0, 32'h69, 3);
        issue(32'h4000_0000, 1'b1, 3'd0, 32'h21, 3);
        issue(32'h4000_0000, 1'b1, 3'd0, 32'h0D, 3);
        drain();
        chk("stream_accepts", 32'(acc_log.size()), 32'd4);
        chk("stream_nonseq", 32'(ns_log.size()), 32'd4);
        chk("stream_rsps", 32'(rsp_log.size()), 32'd4);
        if (acc_log.size() == 4 && ns_log.size() == 4 && rsp_log.size() == 4)
            for (int i = 1; i < 4; i++) begin
                chk("stream_accept_gap", 32'(acc_log[i] - acc_log[i-1]), 32'(STEP));
                chk("stream_nonseq_gap", 32'(ns_log[i] - ns_log[i-1]), 32'(STEP));
                chk("stream_rsp_gap", 32'(rsp_log[i] - rsp_log[i-1]), 32'(STEP));
            end

        // randomized traffic
        for (int n = 0; n < 60; n++) begin
            wait_cfg = $urandom_range(0, 2);
            case ($urandom_range(0, 9))
                0:       a = 32'h8000_0000 + 32'($urandom_range(0, 63));
                1:       a = 32'h4000_0000 + 32'($urandom_range(0, 15));
                default: a = 32'($urandom_range(0, 255));
            endcase
            s = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            issue(a, 1'($urandom_range(0, 1)), s, $urandom, -1);
            if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 2));
        end
        wait_cfg = 0;
        drain();

        // reset while the data phase is stalled
        wait_cfg = 6;
        issue(32'h100, 1'b0, 3'd2, 32'h0, -1);
        if (PIPE) issue(32'h104, 1'b0, 3'd2, 32'h0, -1);
        else tick(1);
        @(negedge HCLK);
        chk("stall_hready", {31'd0, HREADY}, 32'd0);
        if (PIPE) chk("stall_htrans_a", {30'd0, HTRANS}, 32'd2);
        #1 HRESET = 1'b1;
        #1;
        chk("midrst_htrans", {30'd0, HTRANS}, 32'd0);
        chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        expq.delete();
        accq.delete();
        wait_cfg = 0;
        r0 = rsp_log.size();
        repeat (2) @(negedge HCLK);
        HRESET = 1'b0;
        @(negedge HCLK);
        chk("postrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        tick(8);
        chk("postrst_no_rsp", 32'(rsp_log.size() - r0), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
